// File: rtl/lut_table_writer.sv
// Runtime loader and lookup engine for one LogicNets neuron truth table.
// Optional macro LUT_OUT_REG_EN registers the M1 lookup output (1-cycle latency).
module lut_table_writer #(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [OUT_BITS-1:0] s_data,
    input  logic                s_last,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic [IN_BITS-1:0]  M0,
    output logic [OUT_BITS-1:0] M1
);

    localparam int DEPTH = 2 ** IN_BITS;
    localparam logic [IN_BITS-1:0] LAST_IDX = IN_BITS'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                             state_q, state_d;
    logic [IN_BITS-1:0]                 cnt_q, cnt_d;
    logic                               err_q, err_d;
    logic [DEPTH-1:0][OUT_BITS-1:0]     shadow_q, shadow_d;
    logic [DEPTH-1:0][OUT_BITS-1:0]     active_q, active_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // Stream handshake: a beat transfers on any rising edge where s_valid and
    // s_ready are both high; the source must hold s_data/s_last until then.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        shadow_d = shadow_q;
        active_d = active_q;
        s_ready  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) begin
                    shadow_d[cnt_q] = s_data;
                    cnt_d           = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        if (s_last) begin
                            // Copy on the same edge that captures the last entry so
                            // the new table is live while done is high.
                            state_d  = COMMIT;
                            active_d = shadow_d;
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end else if (s_last) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            COMMIT: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign err = err_q;

`ifdef LUT_OUT_REG_EN
    logic [OUT_BITS-1:0] m1_q, m1_d;

    always_comb begin
        m1_d = active_q[M0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_q <= '0;
        end else begin
            m1_q <= m1_d;
        end
    end

    assign M1 = m1_q;
`else
    assign M1 = active_q[M0];
`endif

endmodule

// File: tb/tb_lut_table_writer.sv
// Directed testbench for lut_table_writer: load, commit, framing errors, reset.
// Build with +define+LUT_OUT_REG_EN to exercise the registered lookup path.
module tb_lut_table_writer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       s_valid;
    logic       s_ready;
    logic [1:0] s_data;
    logic       s_last;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] M0;
    logic [1:0] M1;

    int total = 0;
    int bad   = 0;

    logic [1:0] tab_a   [16] = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd3, 2'd3,
                                 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3};
    logic [1:0] tab_b   [16];
    logic [1:0] act_exp [16];

    lut_table_writer #(.IN_BITS(4), .OUT_BITS(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .M0      (M0),
        .M1      (M1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [1:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic read_m1(input logic [3:0] addr, output logic [1:0] val);
        M0 = addr;
`ifdef LUT_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        val = M1;
    endtask

    // tests
    task automatic test_reset();
        logic [1:0] v;
        for (int a = 0; a < 16; a++) begin
            read_m1(4'(a), v);
            total++;
            if (v !== 2'd0) begin
                bad++;
                $display("FAIL reset_m1 addr=%0d got=%0d exp=0", a, v);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        total++;
        if ({s_ready, busy, done, err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got ready/busy/done/err=%b exp=0000",
                     {s_ready, busy, done, err});
        end
    endtask

    task automatic test_full_load();
        logic [1:0] v;
        do_start();
        total++;
        if ({s_ready, busy} !== 2'b11) begin
            bad++;
            $display("FAIL load_open got ready/busy=%b exp=11", {s_ready, busy});
        end
        for (int k = 0; k < 16; k++) begin
            send_beat(tab_a[k], k == 15);
            if (k < 15) begin
                total++;
                if (done !== 1'b0) begin
                    bad++;
                    $display("FAIL early_done beat=%0d got=%b exp=0", k, done);
                end
            end
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL commit_done got=%b exp=1", done);
        end
        M0 = 4'd2;
        #1;
`ifdef LUT_OUT_REG_EN
        @(posedge clk);
        #1;
        total++;
        if (M1 !== 2'd3) begin
            bad++;
            $display("FAIL reg_m1_after_commit got=%0d exp=3", M1);
        end
        M0 = 4'd11;
        #1;
        total++;
        if (M1 !== 2'd3) begin
            bad++;
            $display("FAIL reg_m1_lag got=%0d exp=3", M1);
        end
        @(posedge clk);
        #1;
        total++;
        if (M1 !== 2'd2) begin
            bad++;
            $display("FAIL reg_m1_next got=%0d exp=2", M1);
        end
`else
        total++;
        if (M1 !== 2'd3) begin
            bad++;
            $display("FAIL comb_m1_with_done got=%0d exp=3", M1);
        end
        @(posedge clk);
        #1;
`endif
        total++;
        if ({done, busy, s_ready} !== 3'b000) begin
            bad++;
            $display("FAIL after_commit got done/busy/ready=%b exp=000", {done, busy, s_ready});
        end
        for (int a = 0; a < 16; a++) act_exp[a] = tab_a[a];
        read_m1(4'd2, v);
        total++;
        if (v !== 2'b11) begin
            bad++;
            $display("FAIL lookup_2 got=%0d exp=3", v);
        end
        read_m1(4'd13, v);
        total++;
        if (v !== 2'b00) begin
            bad++;
            $display("FAIL lookup_13 got=%0d exp=0", v);
        end
        for (int a = 0; a < 16; a++) begin
            read_m1(4'(a), v);
            total++;
            if (v !== act_exp[a]) begin
                bad++;
                $display("FAIL sweep_a addr=%0d got=%0d exp=%0d", a, v, act_exp[a]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] v;
        M0 = 4'd5;
        do_start();
        for (int k = 0; k < 16; k++) begin
            if (k % 3 == 1) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
                total++;
                if ({s_ready, M1} !== {1'b1, 2'd1}) begin
                    bad++;
                    $display("FAIL gap beat=%0d got ready=%b m1=%0d exp ready=1 m1=1",
                             k, s_ready, M1);
                end
            end
            send_beat(tab_b[k], k == 15);
            if (k < 15) begin
                total++;
                if (M1 !== 2'd1) begin
                    bad++;
                    $display("FAIL old_table_in_service beat=%0d got=%0d exp=1", k, M1);
                end
            end
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done got=%b exp=1", done);
        end
`ifdef LUT_OUT_REG_EN
        total++;
        if (M1 !== 2'd1) begin
            bad++;
            $display("FAIL b2b_reg_lag got=%0d exp=1", M1);
        end
        @(posedge clk);
        #1;
`endif
        total++;
        if (M1 !== 2'd2) begin
            bad++;
            $display("FAIL b2b_new_value got=%0d exp=2", M1);
        end
        for (int a = 0; a < 16; a++) act_exp[a] = tab_b[a];
        for (int a = 0; a < 16; a++) begin
            read_m1(4'(a), v);
            total++;
            if (v !== act_exp[a]) begin
                bad++;
                $display("FAIL sweep_b addr=%0d got=%0d exp=%0d", a, v, act_exp[a]);
            end
        end
    endtask

    task automatic test_short_last();
        logic [1:0] v;
        do_start();
        for (int k = 0; k < 9; k++) begin
            send_beat(2'(k), k == 8);
            if (k < 8) begin
                total++;
                if (err !== 1'b0) begin
                    bad++;
                    $display("FAIL short_early_err beat=%0d got=%b exp=0", k, err);
                end
            end
        end
        total++;
        if ({err, done, s_ready, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL short_last got err/done/ready/busy=%b exp=1000",
                     {err, done, s_ready, busy});
        end
        @(posedge clk);
        #1;
        total++;
        if ({err, done} !== 2'b10) begin
            bad++;
            $display("FAIL short_sticky got err/done=%b exp=10", {err, done});
        end
        for (int a = 0; a < 16; a++) begin
            read_m1(4'(a), v);
            total++;
            if (v !== act_exp[a]) begin
                bad++;
                $display("FAIL short_untouched addr=%0d got=%0d exp=%0d", a, v, act_exp[a]);
            end
        end
    endtask

    task automatic test_no_last();
        logic [1:0] v;
        do_start();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL start_clears_err got=%b exp=0", err);
        end
        for (int k = 0; k < 16; k++) begin
            send_beat(2'd3, 1'b0);
            if (k == 14) begin
                total++;
                if (err !== 1'b0) begin
                    bad++;
                    $display("FAIL nolast_early_err got=%b exp=0", err);
                end
            end
        end
        total++;
        if ({err, done, s_ready, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL no_last got err/done/ready/busy=%b exp=1000",
                     {err, done, s_ready, busy});
        end
        for (int a = 0; a < 16; a++) begin
            read_m1(4'(a), v);
            total++;
            if (v !== act_exp[a]) begin
                bad++;
                $display("FAIL nolast_untouched addr=%0d got=%0d exp=%0d", a, v, act_exp[a]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [1:0] v;
        do_start();
        for (int k = 0; k < 7; k++) send_beat(2'd1, 1'b0);
        rst_n = 1'b0;
        #1;
        total++;
        if ({s_ready, busy, done, err} !== 4'b0000) begin
            bad++;
            $display("FAIL midreset_flags got ready/busy/done/err=%b exp=0000",
                     {s_ready, busy, done, err});
        end
        for (int a = 0; a < 16; a++) act_exp[a] = 2'd0;
        for (int a = 0; a < 16; a++) begin
            read_m1(4'(a), v);
            total++;
            if (v !== act_exp[a]) begin
                bad++;
                $display("FAIL midreset_m1 addr=%0d got=%0d exp=0", a, v);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        read_m1(4'd5, v);
        total++;
        if ({v, busy} !== 3'b000) begin
            bad++;
            $display("FAIL post_reset got m1=%0d busy=%b exp m1=0 busy=0", v, busy);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 2'd0;
        s_last  = 1'b0;
        M0      = 4'd0;
        for (int a = 0; a < 16; a++) begin
            tab_b[a]   = ~tab_a[a];
            act_exp[a] = 2'd0;
        end
        test_reset();
        test_full_load();
        test_back_to_back();
        test_short_last();
        test_no_last();
        test_reset_mid_load();
        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
